// File: rtl/probe_capture_core.sv
// probe_capture_core: circular-history capture core for debug probes.
// Samples probe_i into a DEPTH-deep ring while armed, stops a programmable
// number of samples after a masked trigger, then streams the window
// oldest-first as bytes (LSB byte first) on a valid/ready port.
// Optional sample decimation is enabled by defining PROBE_CAPTURE_DECIM_EN.
module probe_capture_core #(
   parameter int unsigned PROBE_W = 30,
   parameter int unsigned DEPTH   = 512,
   parameter int unsigned DECIM_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PROBE_W-1:0]         probe_i,
   input  logic                       arm_i,
   input  logic                       abort_i,
   input  logic [PROBE_W-1:0]         trig_mask_i,
   input  logic [PROBE_W-1:0]         trig_val_i,
   input  logic [$clog2(DEPTH)-1:0]   post_cnt_i,
   input  logic [DECIM_W-1:0]         decim_i,
   output logic                       busy_o,
   output logic                       triggered_o,
   output logic                       done_o,
   output logic                       rd_valid_o,
   output logic [7:0]                 rd_data_o,
   input  logic                       rd_ready_i
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned FW    = AW + 1;
   localparam int unsigned BYTES = (PROBE_W + 7) / 8;
   localparam int unsigned PW    = BYTES * 8;
   localparam int unsigned BCW   = 4;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ARMED = 3'd1;
   localparam logic [2:0] POST  = 3'd2;
   localparam logic [2:0] DUMP  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]         state, stateNext;
   logic [PROBE_W-1:0] trigMaskQ, trigValQ;
   logic [AW-1:0]      postCfg, postCnt, preVal, wrPtr, rdAddr;
   logic [FW-1:0]      fillCnt, wordsIssued;
   logic               sampleEn, armAcc, wrEn, trigHit, trigFire;

   logic [PROBE_W-1:0] mem [DEPTH];
   logic [PROBE_W-1:0] memQ, pfData, wordIn;
   logic               rdPend, pfValid, outFree, haveWord, consume, heldNext, issue, lastAccept;
   logic [PW-1:0]      shReg, wordPad;
   logic [BCW-1:0]     byteCnt;

`ifdef PROBE_CAPTURE_DECIM_EN
   logic [DECIM_W-1:0] decimCfg, decimCnt;

   // Decimation counter, restarted on arm so the first armed cycle samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         decimCfg <= '0;
         decimCnt <= '0;
      end else if (armAcc) begin
         decimCfg <= decim_i;
         decimCnt <= '0;
      end else if (decimCnt >= decimCfg) begin
         decimCnt <= '0;
      end else begin
         decimCnt <= decimCnt + DECIM_W'(1);
      end
   end

   assign sampleEn = (decimCnt == '0);
`else
   logic unusedDecim;
   assign unusedDecim = ^decim_i;
   assign sampleEn    = 1'b1;
`endif

   // Capture qualifiers: arm acceptance, ring write, eligible trigger
   always_comb begin
      armAcc   = 1'b0;
      wrEn     = 1'b0;
      trigFire = 1'b0;
      preVal   = AW'(DEPTH - 1) - postCfg;
      trigHit  = (((probe_i ^ trigValQ) & trigMaskQ) == '0);
      if (!abort_i) begin
         armAcc   = arm_i && ((state == IDLE) || (state == DONE));
         wrEn     = sampleEn && ((state == ARMED) || (state == POST));
         trigFire = sampleEn && (state == ARMED) && trigHit && (fillCnt >= FW'(preVal));
      end
   end

   // Dump pipeline control: one word in flight or held in the prefetch register
   always_comb begin
      outFree    = !rd_valid_o || rd_ready_i;
      haveWord   = pfValid || rdPend;
      wordIn     = pfValid ? pfData : memQ;
      wordPad    = PW'(wordIn);
      consume    = outFree && (byteCnt == '0) && haveWord;
      heldNext   = (pfValid && rdPend) || (haveWord && !consume);
      issue      = (state == DUMP) && !abort_i && (wordsIssued != FW'(DEPTH)) && !heldNext;
      rdAddr     = wrPtr + wordsIssued[AW-1:0];
      lastAccept = rd_valid_o && rd_ready_i && (byteCnt == '0) && !haveWord
                   && (wordsIssued == FW'(DEPTH));
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      if (abort_i) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (armAcc) stateNext = ARMED;
            ARMED:      if (trigFire) stateNext = (postCfg == '0) ? DUMP : POST;
            POST:       if (wrEn && (postCnt == AW'(1))) stateNext = DUMP;
            DUMP:       if (lastAccept) stateNext = DONE;
            default:    stateNext = IDLE;
         endcase
      end
   end

   // State, configuration, write pointer and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         trigMaskQ   <= '0;
         trigValQ    <= '0;
         postCfg     <= '0;
         postCnt     <= '0;
         wrPtr       <= '0;
         fillCnt     <= '0;
         busy_o      <= 1'b0;
         triggered_o <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state  <= stateNext;
         busy_o <= (stateNext == ARMED) || (stateNext == POST) || (stateNext == DUMP);
         if (armAcc) begin
            // post_cnt_i is AW bits wide, so it can never exceed DEPTH-1
            trigMaskQ   <= trig_mask_i;
            trigValQ    <= trig_val_i;
            postCfg     <= post_cnt_i;
            wrPtr       <= '0;
            fillCnt     <= '0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
         end else begin
            if (wrEn) begin
               wrPtr <= wrPtr + AW'(1);
               if (fillCnt != FW'(DEPTH)) fillCnt <= fillCnt + FW'(1);
            end
            if (trigFire) begin
               triggered_o <= 1'b1;
               postCnt     <= postCfg;
            end else if (wrEn && (state == POST)) begin
               postCnt <= postCnt - AW'(1);
            end
            if (lastAccept && !abort_i) done_o <= 1'b1;
         end
         if (abort_i) begin
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
         end
      end
   end

   // Simple dual-port sample memory with registered read
   always_ff @(posedge clk) begin
      if (wrEn) mem[wrPtr] <= probe_i;
      memQ <= mem[rdAddr];
   end

   // Dump datapath: read issue, prefetch register and byte serialiser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wordsIssued <= '0;
         rdPend      <= 1'b0;
         pfValid     <= 1'b0;
         pfData      <= '0;
         shReg       <= '0;
         byteCnt     <= '0;
         rd_valid_o  <= 1'b0;
         rd_data_o   <= '0;
      end else if (abort_i || (state != DUMP)) begin
         wordsIssued <= '0;
         rdPend      <= 1'b0;
         pfValid     <= 1'b0;
         byteCnt     <= '0;
         rd_valid_o  <= 1'b0;
      end else begin
         rdPend <= issue;
         if (issue) wordsIssued <= wordsIssued + FW'(1);
         if (consume && pfValid) begin
            pfValid <= rdPend;
            pfData  <= memQ;
         end else if (!consume && rdPend) begin
            pfValid <= 1'b1;
            pfData  <= memQ;
         end
         if (outFree) begin
            if (byteCnt != '0) begin
               rd_data_o  <= shReg[7:0];
               shReg      <= shReg >> 8;
               byteCnt    <= byteCnt - BCW'(1);
               rd_valid_o <= 1'b1;
            end else if (haveWord) begin
               rd_data_o  <= wordPad[7:0];
               shReg      <= wordPad >> 8;
               byteCnt    <= BCW'(BYTES - 1);
               rd_valid_o <= 1'b1;
            end else begin
               rd_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_probe_capture_core.sv
// tb_probe_capture_core: directed bench for probe_capture_core
// (PROBE_W=12, DEPTH=16, so 2 bytes per sample and 32 bytes per dump).
module tb_probe_capture_core;

   localparam int unsigned PW     = 12;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned NBYTES = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [PW-1:0] probe_i, trig_mask_i, trig_val_i;
   logic          arm_i, abort_i, rd_ready_i;
   logic [3:0]    post_cnt_i;
   logic [7:0]    decim_i;
   logic          busy_o, triggered_o, done_o, rd_valid_o;
   logic [7:0]    rd_data_o;

   int nVec = 0;
   int nMis = 0;
   int rxCount;
   logic [PW-1:0] seq [64];
   logic [PW-1:0] expWin [DEPTH];
   logic [7:0]    rxBytes [NBYTES];
   logic [7:0]    refBytes [NBYTES];
   bit            ok;

   probe_capture_core #(.PROBE_W(PW), .DEPTH(DEPTH), .DECIM_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .probe_i(probe_i), .arm_i(arm_i), .abort_i(abort_i),
      .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i), .post_cnt_i(post_cnt_i),
      .decim_i(decim_i), .busy_o(busy_o), .triggered_o(triggered_o), .done_o(done_o),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic startArm(input logic [PW-1:0] mask, input logic [PW-1:0] val,
                           input logic [3:0] post, input logic [7:0] decim);
      trig_mask_i = mask;
      trig_val_i  = val;
      post_cnt_i  = post;
      decim_i     = decim;
      probe_i     = '0;
      rd_ready_i  = 1'b1;
      arm_i       = 1'b1;
      @(negedge clk);
      arm_i = 1'b0;
      checkVal("armBusy", 32'(busy_o), 32'd1);
      checkVal("armTrigClr", 32'(triggered_o), 32'd0);
      checkVal("armDoneClr", 32'(done_o), 32'd0);
   endtask

   // Feed seq[] one sample per cycle until the first dump byte shows up
   task automatic waitDump(output bit started);
      int k = 0;
      while (!rd_valid_o && k < 64) begin
         probe_i = seq[k];
         k++;
         @(negedge clk);
      end
      started = rd_valid_o;
      if (!started) checkVal("dumpStartTimeout", 32'd0, 32'd1);
   endtask

   task automatic collectDump(input bit stall, input int armAt, input int abortAt);
      bit         held = 1'b0;
      bit         armDone = 1'b0;
      logic [7:0] heldData = '0;
      int         cyc = 0;
      rxCount = 0;
      while (rxCount < NBYTES && cyc < 400) begin
         if (held) begin
            checkVal("stallValid", 32'(rd_valid_o), 32'd1);
            checkVal("stallData", 32'(rd_data_o), 32'(heldData));
         end
         if (rxCount == abortAt) begin
            abort_i    = 1'b1;
            rd_ready_i = 1'b0;
            @(negedge clk);
            abort_i = 1'b0;
            return;
         end
         arm_i = 1'b0;
         if (rxCount == armAt && !armDone) begin
            arm_i   = 1'b1;
            armDone = 1'b1;
         end
         rd_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         held       = rd_valid_o && !rd_ready_i;
         heldData   = rd_data_o;
         if (rd_valid_o && rd_ready_i) begin
            rxBytes[rxCount] = rd_data_o;
            rxCount++;
         end
         @(negedge clk);
         cyc++;
      end
      arm_i      = 1'b0;
      rd_ready_i = 1'b1;
      checkVal("dumpByteCount", 32'(rxCount), 32'(NBYTES));
      checkVal("endValidDrop", 32'(rd_valid_o), 32'd0);
      checkVal("endDone", 32'(done_o), 32'd1);
      checkVal("endBusy", 32'(busy_o), 32'd0);
   endtask

   task automatic checkWindow(input string tag);
      for (int i = 0; i < DEPTH; i++)
         checkVal($sformatf("%s[%0d]", tag, i), {16'h0, rxBytes[2*i+1], rxBytes[2*i]},
                  {20'h0, expWin[i]});
   endtask

   task automatic checkIdle(input string tag);
      checkVal({tag, "Busy"}, 32'(busy_o), 32'd0);
      checkVal({tag, "Trig"}, 32'(triggered_o), 32'd0);
      checkVal({tag, "Done"}, 32'(done_o), 32'd0);
      checkVal({tag, "Valid"}, 32'(rd_valid_o), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      probe_i = '0; trig_mask_i = '0; trig_val_i = '0; post_cnt_i = '0; decim_i = '0;
      arm_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      checkIdle("rst");
      checkVal("rstData", 32'(rd_data_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic capture: samples 1,2,3..., trigger on 0x00C (first eligible fill), post 4
      for (int k = 0; k < 64; k++) seq[k] = PW'(k + 1);
      for (int i = 0; i < DEPTH; i++) expWin[i] = PW'(i + 1);
      startArm(12'hFFF, 12'h00C, 4'd4, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, -1);
         checkWindow("t1");
         checkVal("t1Trig", 32'(triggered_o), 32'd1);
      end
      for (int i = 0; i < NBYTES; i++) refBytes[i] = rxBytes[i];

      // Zero mask, zero post: trigger as soon as 15 samples are stored
      for (int k = 0; k < 64; k++) seq[k] = PW'(k);
      for (int i = 0; i < DEPTH; i++) expWin[i] = PW'(i);
      startArm(12'h000, 12'h000, 4'd0, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, -1);
         checkWindow("t2");
         checkVal("t2Trig", 32'(triggered_o), 32'd1);
      end

      // Early match at fill 3 must be ignored, match at fill 13 used
      for (int k = 0; k < 64; k++) seq[k] = PW'(12'h100 + k);
      seq[3]  = 12'h055;
      seq[13] = 12'h055;
      for (int i = 0; i < DEPTH; i++) expWin[i] = seq[i + 2];
      startArm(12'hFFF, 12'h055, 4'd4, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, -1);
         checkWindow("t3");
      end

      // Random consumer stalls plus an ignored arm mid-dump
      for (int k = 0; k < 64; k++) seq[k] = PW'(k + 1);
      startArm(12'hFFF, 12'h00C, 4'd4, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b1, 10, -1);
         for (int i = 0; i < NBYTES; i++)
            checkVal($sformatf("stallByte[%0d]", i), 32'(rxBytes[i]), 32'(refBytes[i]));
      end

      // Abort while in POST (trigger at cycle 11, abort at cycle 13)
      startArm(12'hFFF, 12'h00C, 4'd4, 8'd0);
      for (int k = 0; k < 13; k++) begin
         probe_i = seq[k];
         @(negedge clk);
      end
      checkVal("postTrig", 32'(triggered_o), 32'd1);
      abort_i = 1'b1;
      probe_i = seq[13];
      @(negedge clk);
      abort_i = 1'b0;
      checkIdle("abPost");
      @(negedge clk);
      checkVal("abPostStill", 32'(rd_valid_o), 32'd0);

      // Abort in mid-dump after 5 bytes, then a full capture
      for (int k = 0; k < 64; k++) seq[k] = PW'(k);
      startArm(12'h000, 12'h000, 4'd0, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, 5);
         checkIdle("abDump");
      end
      for (int k = 0; k < 64; k++) seq[k] = PW'(k + 1);
      for (int i = 0; i < DEPTH; i++) expWin[i] = PW'(i + 1);
      startArm(12'hFFF, 12'h00C, 4'd4, 8'd0);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, -1);
         checkWindow("t5");
      end

`ifdef PROBE_CAPTURE_DECIM_EN
      // Every third cycle sampled; match at unsampled cycle 40 must not fire
      for (int k = 0; k < 64; k++) seq[k] = PW'(k);
      seq[40] = 12'h02A;
      for (int i = 0; i < DEPTH; i++) expWin[i] = PW'(3 * (i + 3));
      startArm(12'hFFF, 12'h02A, 4'd4, 8'd2);
      waitDump(ok);
      if (ok) begin
         collectDump(1'b0, -1, -1);
         checkWindow("dec");
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
